// File: rtl/prime_factor_if.sv
// Handshake bundle for prime_factor: request/status, factor output stream,
// and the link to the upstream prime generator.
// PRIME_FACTOR_MERGE_EN adds out_exp (multiplicity of each emitted prime).
interface prime_factor_if;
    logic        start;
    logic [15:0] n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
`ifdef PRIME_FACTOR_MERGE_EN
    logic [3:0]  out_exp;
`endif
    logic        done;
    logic        error;
    logic        busy;
    logic        pg_rst;
    logic        pg_go;
    logic        pg_ready;
    logic        pg_error;
    logic [15:0] pg_res;

    // Factoring block side
    modport master (
`ifdef PRIME_FACTOR_MERGE_EN
        output out_exp,
`endif
        input  start, n, out_ready, pg_ready, pg_error, pg_res,
        output out_valid, out_res, done, error, busy, pg_rst, pg_go
    );

    // Environment side (requester, consumer, prime generator)
    modport slave (
`ifdef PRIME_FACTOR_MERGE_EN
        input  out_exp,
`endif
        output start, n, out_ready, pg_ready, pg_error, pg_res,
        input  out_valid, out_res, done, error, busy, pg_rst, pg_go
    );
endinterface

// File: rtl/prime_factor.sv
// Prime factorisation of a 16-bit value by trial division against primes
// streamed from an external generator. Each candidate division is a 16-step
// restoring divider (one quotient bit per cycle, no multiplier).
// Optional feature: PRIME_FACTOR_MERGE_EN -- emit each distinct prime once
// together with its multiplicity on out_exp instead of once per multiplicity.
module prime_factor (
    input  logic          clk,
    input  logic          rst,
    prime_factor_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, PG_RESET, PG_WAIT, DIVIDE, EMIT, NEXT, FINISH
    } state_t;

    // What to do once the consumer takes the factor currently on out_res
    typedef enum logic [1:0] {
        POST_FINISH, POST_DIVIDE, POST_NEXT, POST_EMIT_M
    } post_t;

    state_t      state;
    post_t       post;
    logic [15:0] m;         // remaining cofactor
    logic [15:0] p;         // current trial prime
    logic [15:0] rem;       // divider partial remainder (always < p)
    logic [15:0] quo;       // dividend shifting out / quotient shifting in
    logic [3:0]  cnt;       // divider step
    logic        discard;   // next generator value is the post-reset dummy 1
    logic        seen_low;  // pg_ready has been low since the last pg_go
`ifdef PRIME_FACTOR_MERGE_EN
    logic [3:0]  exp_cnt;   // multiplicity of p found so far
`endif

    logic [16:0] rem_sh;
    logic [17:0] diff;
    logic [15:0] rem_n;
    logic [15:0] quo_n;

    // One restoring-division step: shift in next dividend bit, trial subtract
    always_comb begin
        rem_sh = {rem, quo[15]};
        diff   = {1'b0, rem_sh} - {2'b00, p};
        if (diff[17]) begin
            rem_n = rem_sh[15:0];
            quo_n = {quo[14:0], 1'b0};
        end else begin
            rem_n = diff[15:0];
            quo_n = {quo[14:0], 1'b1};
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            post          <= POST_FINISH;
            m             <= '0;
            p             <= '0;
            rem           <= '0;
            quo           <= '0;
            cnt           <= '0;
            discard       <= 1'b0;
            seen_low      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_res   <= '0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.pg_go     <= 1'b0;
            bus.pg_rst    <= 1'b0;
`ifdef PRIME_FACTOR_MERGE_EN
            exp_cnt       <= '0;
            bus.out_exp   <= '0;
`endif
        end else begin
            // Pulsed outputs default low
            bus.done   <= 1'b0;
            bus.pg_go  <= 1'b0;
            bus.pg_rst <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy  <= 1'b1;
                        bus.error <= 1'b0;
`ifdef PRIME_FACTOR_MERGE_EN
                        exp_cnt   <= '0;
`endif
                        if (bus.n == 16'd0) begin
                            bus.error <= 1'b1;
                            state     <= FINISH;
                        end else if (bus.n == 16'd1) begin
                            state <= FINISH;
                        end else begin
                            m          <= bus.n;
                            bus.pg_rst <= 1'b1;
                            state      <= PG_RESET;
                        end
                    end
                end

                PG_RESET: begin
                    // The generator restarts from its dummy value; its ready
                    // need not toggle first, so treat the low phase as seen.
                    discard  <= 1'b1;
                    seen_low <= 1'b1;
                    state    <= PG_WAIT;
                end

                PG_WAIT: begin
                    if (bus.pg_error) begin
                        bus.error <= 1'b1;
                        state     <= FINISH;
                    end else if (!bus.pg_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        if (discard) begin
                            discard   <= 1'b0;
                            seen_low  <= 1'b0;
                            bus.pg_go <= 1'b1;
                        end else begin
                            p     <= bus.pg_res;
                            rem   <= '0;
                            quo   <= m;
                            cnt   <= '0;
                            state <= DIVIDE;
                        end
                    end
                end

                DIVIDE: begin
                    rem <= rem_n;
                    quo <= quo_n;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
`ifdef PRIME_FACTOR_MERGE_EN
                        if (rem_n == '0) begin
                            m       <= quo_n;
                            exp_cnt <= exp_cnt + 4'd1;
                            if (quo_n == 16'd1) begin
                                bus.out_res   <= p;
                                bus.out_exp   <= exp_cnt + 4'd1;
                                bus.out_valid <= 1'b1;
                                post          <= POST_FINISH;
                                state         <= EMIT;
                            end else begin
                                // Same prime again on the reduced cofactor
                                rem <= '0;
                                quo <= quo_n;
                                cnt <= '0;
                            end
                        end else if (exp_cnt != '0) begin
                            bus.out_res   <= p;
                            bus.out_exp   <= exp_cnt;
                            bus.out_valid <= 1'b1;
                            post          <= (quo_n < p) ? POST_EMIT_M : POST_NEXT;
                            state         <= EMIT;
                        end else if (quo_n < p) begin
                            bus.out_res   <= m;
                            bus.out_exp   <= 4'd1;
                            bus.out_valid <= 1'b1;
                            post          <= POST_FINISH;
                            state         <= EMIT;
                        end else begin
                            state <= NEXT;
                        end
`else
                        if (rem_n == '0) begin
                            m             <= quo_n;
                            bus.out_res   <= p;
                            bus.out_valid <= 1'b1;
                            post          <= (quo_n == 16'd1) ? POST_FINISH : POST_DIVIDE;
                            state         <= EMIT;
                        end else if (quo_n < p) begin
                            // p*p > m with no divisor found: m itself is prime
                            bus.out_res   <= m;
                            bus.out_valid <= 1'b1;
                            post          <= POST_FINISH;
                            state         <= EMIT;
                        end else begin
                            state <= NEXT;
                        end
`endif
                    end
                end

                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        case (post)
                            POST_DIVIDE: begin
                                rem   <= '0;
                                quo   <= m;
                                cnt   <= '0;
                                state <= DIVIDE;
                            end
                            POST_NEXT:   state <= NEXT;
                            POST_EMIT_M: begin
                                // Leftover cofactor is prime; emit it next
                                bus.out_res   <= m;
                                bus.out_valid <= 1'b1;
`ifdef PRIME_FACTOR_MERGE_EN
                                bus.out_exp   <= 4'd1;
`endif
                                post          <= POST_FINISH;
                            end
                            default:     state <= FINISH;
                        endcase
                    end
                end

                NEXT: begin
                    bus.pg_go <= 1'b1;
                    seen_low  <= 1'b0;
`ifdef PRIME_FACTOR_MERGE_EN
                    exp_cnt   <= '0;
`endif
                    state     <= PG_WAIT;
                end

                FINISH: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_factor.sv
// Self-checking bench for prime_factor: behavioural prime generator,
// scoreboard of expected factors, stall/reset/error scenarios.
module tb_prime_factor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prime_factor_if bus();

    prime_factor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int exp_q[$];       // {exponent, factor} packed as exp<<16 | factor
    int accepted = 0;
    int max_prime = 0;
    bit hold_ready = 1'b0;
    bit stall_mode = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit is_prime(input int x);
        if (x < 2) return 1'b0;
        for (int d = 2; d * d <= x; d++)
            if (x % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(input int x);
        int y;
        y = x + 1;
        while (!is_prime(y)) y++;
        return y;
    endfunction

    function automatic void push_factor(input int f, input int c);
`ifdef PRIME_FACTOR_MERGE_EN
        exp_q.push_back((c << 16) | f);
`else
        for (int i = 0; i < c; i++) exp_q.push_back((1 << 16) | f);
`endif
    endfunction

    function automatic void push_expected(input int val);
        int v;
        int c;
        v = val;
        if (v < 2) return;
        for (int d = 2; d * d <= v; d++) begin
            c = 0;
            while (v % d == 0) begin
                v = v / d;
                c++;
            end
            if (c > 0) push_factor(d, c);
        end
        if (v > 1) push_factor(v, 1);
    endfunction

    // Prime generator model: ready drops for two cycles after pg_rst/pg_go
    initial begin
        int cur;
        int lat;
        cur = 1;
        lat = 0;
        bus.pg_ready = 1'b0;
        bus.pg_res   = '0;
        forever begin
            @(negedge clk);
            if (bus.pg_rst) begin
                bus.pg_ready = 1'b0;
                cur = 1;
                lat = 2;
            end else if (bus.pg_go) begin
                bus.pg_ready = 1'b0;
                cur = next_prime(cur);
                if (cur > max_prime) max_prime = cur;
                lat = 2;
            end else if (lat > 1) begin
                lat--;
            end else if (lat == 1 && !hold_ready) begin
                lat = 0;
                bus.pg_ready = 1'b1;
                bus.pg_res   = cur[15:0];
            end
        end
    end

    // Consumer: drives out_ready, checks stall stability, pops scoreboard
    initial begin
        int stall_cnt;
        int e;
        logic [15:0] held;
        stall_cnt = 0;
        held = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!stall_mode) begin
                bus.out_ready = 1'b1;
                stall_cnt = 0;
            end else if (bus.out_valid) begin
                if (stall_cnt == 0) held = bus.out_res;
                else check("stall_hold", bus.out_res, held);
                if (stall_cnt < 5) begin
                    bus.out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    bus.out_ready = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                bus.out_ready = 1'b0;
                stall_cnt = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_factor", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("factor", bus.out_res, e & 16'hFFFF);
`ifdef PRIME_FACTOR_MERGE_EN
                    check("exponent", bus.out_exp, e >> 16);
`endif
                    accepted++;
                end
            end
        end
    end

    task automatic pulse_start(input logic [15:0] val);
        @(negedge clk);
        bus.start = 1'b1;
        bus.n     = val;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 1;
        while (!bus.done && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", bus.done, 1'b1);
        if (bus.done) begin
            check("busy_at_done", bus.busy, 1'b0);
            @(negedge clk);
            check("done_pulse", bus.done, 1'b0);
        end
    endtask

    task automatic run(input logic [15:0] val, input int bound, input logic err);
        int cyc;
        push_expected(val);
        pulse_start(val);
        wait_done(bound, cyc);
        check("error", bus.error, err);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        bus.start    = 1'b0;
        bus.n        = '0;
        bus.pg_error = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_pg", {bus.pg_go, bus.pg_rst, bus.done, bus.error}, 4'b0000);
        check("rst_out_res", bus.out_res, 16'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic factorisation
        run(16'd12, 500, 1'b0);

        // Trivial inputs
        pulse_start(16'd1);
        wait_done(10, cyc);
        check("n1_latency_le3", (cyc <= 3), 1'b1);
        check("n1_error", bus.error, 1'b0);
        run(16'd0, 10, 1'b1);

        // Largest 16-bit prime: every prime up to 257 is tried
        max_prime = 0;
        run(16'd65521, 8000, 1'b0);
        check("max_prime_tried", max_prime, 257);

        // Consumer stalls 5 cycles per factor; a start while busy is ignored
        stall_mode = 1'b1;
        push_expected(30030);
        pulse_start(16'd30030);
        repeat (20) @(negedge clk);
        check("busy_mid_run", bus.busy, 1'b1);
        pulse_start(16'd7);
        wait_done(3000, cyc);
        check("stall_error", bus.error, 1'b0);
        check("stall_drain", exp_q.size(), 0);
        stall_mode = 1'b0;

        // Reset in the middle of the second division
        accepted = 0;
        push_expected(1000);
        pulse_start(16'd1000);
        cyc = 0;
        while (accepted < 1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("first_factor_1000", accepted, 1);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_flags", {bus.busy, bus.done, bus.error, bus.pg_go, bus.pg_rst}, 5'b00000);
        check("mid_rst_res", bus.out_res, 16'd0);
        check("mid_rst_m", dut.m, 16'd0);
        check("mid_rst_p", dut.p, 16'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {bus.done, bus.busy}, 2'b00);
        end
        run(16'd9, 500, 1'b0);

        // Generator error while waiting for a prime
        hold_ready = 1'b1;
        pulse_start(16'd97);
        repeat (6) @(negedge clk);
        bus.pg_error = 1'b1;
        wait_done(20, cyc);
        check("pg_err_error", bus.error, 1'b1);
        bus.pg_error = 1'b0;
        hold_ready   = 1'b0;
        repeat (5) @(negedge clk);
        check("pg_err_sticky", bus.error, 1'b1);
        check("pg_err_no_valid", bus.out_valid, 1'b0);
        check("pg_err_idle", bus.busy, 1'b0);

        // Next accepted start clears error
        run(16'd12, 500, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prime_factor.md
PRIME_FACTOR -- requirements
Module: prime_factor

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  in  1  one-cycle request to factor n; ignored unless idle.
REQ-004 SHALL have: n  in  16  unsigned value to factor, sampled on accepted start.
REQ-005 SHALL have: out_valid  out  1  out_res holds a prime factor.
REQ-006 SHALL have: out_ready  in  1  consumer accepts factor when out_valid&&out_ready.
REQ-007 SHALL have: out_res  out  16  prime factor, non-decreasing order.
REQ-008 SHALL have: done  out  1  one-cycle pulse when factorization ends (success or error).
REQ-009 SHALL have: error  out  1  sticky until next accepted start.
REQ-010 SHALL have: busy  out  1  high from accepted start until done pulse.
REQ-011 SHALL have prime-source ports pg_rst out 1 (active-high sync), pg_go out 1, pg_ready in 1, pg_error in 1, pg_res in 16, wired to the upstream prime generator.

Function
REQ-012 States SHALL be IDLE, PG_RESET, PG_WAIT, DIVIDE, EMIT, NEXT, FINISH.
REQ-013 IDLE: start with n==0 -> error=1, FINISH; n==1 -> FINISH, no factors; else latch m=n, go PG_RESET.
REQ-014 PG_RESET SHALL assert pg_rst for exactly one cycle, then PG_WAIT.
REQ-015 First pg_res after pg_rst (value 1) SHALL be discarded: on pg_ready, pulse pg_go one cycle, wait again.
REQ-016 After any pg_go pulse, block SHALL wait for pg_ready low at least one cycle then high before sampling pg_res into p.
REQ-017 DIVIDE SHALL compute q=m/p, r=m%p with a 16-step restoring divider, exactly 16 cycles, no multiplier.
REQ-018 r==0 -> m=q, EMIT with out_res=p; after acceptance: m==1 -> FINISH, else DIVIDE with same p.
REQ-019 r!=0 and q<p -> m is prime: EMIT out_res=m, then FINISH.
REQ-020 r!=0 and q>=p -> NEXT: pulse pg_go, then PG_WAIT.
REQ-021 EMIT SHALL hold out_valid and out_res stable until out_ready; no state advance while stalled.
REQ-022 pg_error high while waiting on pg_ready SHALL set error, abandon factorization, go FINISH.
REQ-023 FINISH SHALL pulse done one cycle, drop busy, return IDLE.
REQ-024 start while busy SHALL be ignored with no effect.
REQ-025 pg_go and pg_rst SHALL never be high simultaneously.

Reset
REQ-026 rst low SHALL immediately force IDLE and out_valid=0, done=0, error=0, busy=0, pg_go=0, pg_rst=0, out_res=0, m=0, p=0.
REQ-027 Reset mid-factorization SHALL discard all progress; no done pulse on release.

Configuration
REQ-028 Macro PRIME_FACTOR_MERGE_EN defined: extra port out_exp out 4; each distinct prime emitted once with its multiplicity in out_exp, emission deferred until r!=0 or m==1.
REQ-029 PRIME_FACTOR_MERGE_EN undefined: no out_exp port; each factor emitted once per multiplicity per REQ-018.

Verification
REQ-030 n=12, out_ready=1 -> out_res 2,2,3 then done; merged build: (2,2),(3,1).
REQ-031 n=1 -> done within 3 cycles, no out_valid, error=0; n=0 -> done, error=1.
REQ-032 n=65521 -> primes tried up to 257, single factor 65521, done, error=0.
REQ-033 n=30030, out_ready low 5 cycles at each factor -> 2,3,5,7,11,13, out_res stable during each stall.
REQ-034 n=1000, rst low during second DIVIDE -> outputs at reset values; then start n=9 -> 3,3, done.
REQ-035 pg_error forced high in PG_WAIT -> error=1, done pulse, busy low, no further out_valid.
